// File: rtl/pc_gen.sv
// Fetch-stage program counter with a priority next-PC mux and a small circular
// return-address stack used by decode to predict `jr $ra` targets.
module pc_gen #(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = 32'h0000_3000,
  parameter logic [WIDTH-1:0]  EXC_VECTOR   = 32'h0000_4180,
  parameter int unsigned       STEP         = 4,
  parameter int unsigned       RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             exc_req,
  input  logic             eret,
  input  logic [WIDTH-1:0] eret_pc,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             ras_push,
  input  logic [WIDTH-1:0] ras_push_addr,
  input  logic             ras_pop,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_valid,
  output logic             redirected
);

  localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(RAS_DEPTH);

  // Power-up values match the post-reset state so the PC is sane before the first reset.
  logic [WIDTH-1:0] pc_q         = RESET_VECTOR;
  logic [WIDTH-1:0] pc_d;
  logic             redirected_q = 1'b0;
  logic             redirected_d;
  logic [PtrW-1:0]  sp_q         = '0;
  logic [PtrW-1:0]  sp_d;
  logic [CntW-1:0]  count_q      = '0;
  logic [CntW-1:0]  count_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic             ras_we;
  logic [PtrW-1:0]  ras_waddr;
  logic             ras_en;

  assign pc_plus = pc_q + WIDTH'(STEP);

  // Next-PC selection; exception entry beats stall, eret beats redirect.
  always_comb begin
    pc_d         = pc_q;
    redirected_d = 1'b0;
    if (exc_req) begin
      pc_d         = EXC_VECTOR;
      redirected_d = 1'b1;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (eret) begin
      pc_d         = eret_pc;
      redirected_d = 1'b1;
    end else if (redirect) begin
      pc_d         = redirect_pc;
      redirected_d = 1'b1;
    end else begin
      pc_d = pc_plus;
    end
  end

  // RAS next state; ops are suppressed on stall or exception edges.
  always_comb begin
    sp_d      = sp_q;
    count_d   = count_q;
    ras_we    = 1'b0;
    ras_waddr = sp_q;
    ras_en    = !stall && !exc_req;
    if (ras_en) begin
      if (ras_push && ras_pop && (count_q != '0)) begin
        // Replace top in place: a call immediately following a return.
        ras_we    = 1'b1;
        ras_waddr = sp_q;
      end else if (ras_push) begin
        sp_d      = sp_q + PtrW'(1);
        ras_we    = 1'b1;
        ras_waddr = sp_q + PtrW'(1);
        // When full the pointer wrap overwrites the oldest entry.
        count_d   = (count_q == CntFull) ? count_q : count_q + CntW'(1);
      end else if (ras_pop && (count_q != '0)) begin
        sp_d    = sp_q - PtrW'(1);
        count_d = count_q - CntW'(1);
      end
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_VECTOR;
      redirected_q <= 1'b0;
      sp_q         <= '0;
      count_q      <= '0;
    end else begin
      pc_q         <= pc_d;
      redirected_q <= redirected_d;
      sp_q         <= sp_d;
      count_q      <= count_d;
    end
  end

  // RAS entry storage; contents are invisible while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (ras_we && !reset) begin
      ras_q[ras_waddr] <= ras_push_addr;
    end
  end

  assign pc         = pc_q;
  assign redirected = redirected_q;
  assign ras_valid  = (count_q != '0);
  assign ras_top    = ras_valid ? ras_q[sp_q] : '0;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a behavioural model pushes expected outputs to a
// scoreboard queue per driven cycle; they are popped and compared after the edge.
module tb_pc_gen;

  localparam int unsigned W   = 32;
  localparam logic [31:0] RV  = 32'h0000_3000;
  localparam logic [31:0] EV  = 32'h0000_4180;
  localparam int unsigned DEP = 4;

  logic         clk = 1'b0;
  logic         reset, stall, exc_req, eret, redirect, ras_push, ras_pop;
  logic [W-1:0] eret_pc, redirect_pc, ras_push_addr;
  logic [W-1:0] pc, pc_plus, ras_top;
  logic         ras_valid, redirected;

  pc_gen dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .exc_req      (exc_req),
    .eret         (eret),
    .eret_pc      (eret_pc),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .ras_push     (ras_push),
    .ras_push_addr(ras_push_addr),
    .ras_pop      (ras_pop),
    .pc           (pc),
    .pc_plus      (pc_plus),
    .ras_top      (ras_top),
    .ras_valid    (ras_valid),
    .redirected   (redirected)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] plus;
    logic [31:0] top;
    logic        valid;
    logic        redir;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_pc    = RV;
  logic        m_redir = 1'b0;
  logic [31:0] m_ras[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic idle();
    reset = 0; stall = 0; exc_req = 0; eret = 0; redirect = 0;
    ras_push = 0; ras_pop = 0;
    eret_pc = '0; redirect_pc = '0; ras_push_addr = '0;
  endtask

  // Model one edge from the currently driven inputs, then compare after the edge.
  task automatic tick(input string tag);
    exp_t e, got;
    if (reset) begin
      m_pc = RV; m_redir = 0; m_ras.delete();
    end else if (exc_req) begin
      m_pc = EV; m_redir = 1;
    end else if (stall) begin
      m_redir = 0;
    end else begin
      if (eret)          begin m_pc = eret_pc;     m_redir = 1; end
      else if (redirect) begin m_pc = redirect_pc; m_redir = 1; end
      else               begin m_pc = m_pc + 32'd4; m_redir = 0; end
      if (ras_push && ras_pop && m_ras.size() > 0) begin
        m_ras[m_ras.size()-1] = ras_push_addr;
      end else if (ras_push) begin
        m_ras.push_back(ras_push_addr);
        if (m_ras.size() > DEP) void'(m_ras.pop_front());
      end else if (ras_pop && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
    end
    e.pc    = m_pc;
    e.plus  = m_pc + 32'd4;
    e.valid = (m_ras.size() != 0);
    e.top   = e.valid ? m_ras[m_ras.size()-1] : 32'h0;
    e.redir = m_redir;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check({tag, ".pc"},         pc,                got.pc);
    check({tag, ".pc_plus"},    pc_plus,           got.plus);
    check({tag, ".ras_top"},    ras_top,           got.top);
    check({tag, ".ras_valid"},  {31'b0, ras_valid}, {31'b0, got.valid});
    check({tag, ".redirected"}, {31'b0, redirected}, {31'b0, got.redir});
  endtask

  initial begin
    idle();
    #1;
    check("powerup.pc", pc, RV);
    check("powerup.ras_valid", {31'b0, ras_valid}, 32'h0);

    // Reset then free-running
    reset = 1; tick("rst");
    check("rst.pc", pc, 32'h3000);
    idle();
    for (int i = 0; i < 3; i++) tick("seq");
    check("seq.pc", pc, 32'h300C);
    check("seq.redir", {31'b0, redirected}, 32'h0);
    tick("seq4");
    check("seq4.pc", pc, 32'h3010);

    // Stall then exception during stall
    stall = 1; tick("stall");
    check("stall.pc", pc, 32'h3010);
    exc_req = 1; tick("exc");
    check("exc.pc", pc, 32'h4180);
    check("exc.redir", {31'b0, redirected}, 32'h1);
    idle(); tick("post_exc");
    check("post_exc.redir", {31'b0, redirected}, 32'h0);

    // eret beats redirect
    redirect = 1; redirect_pc = 32'h3100; eret = 1; eret_pc = 32'h3200;
    tick("eret_redir");
    check("eret_redir.pc", pc, 32'h3200);
    idle(); tick("after_eret");
    check("after_eret.pc", pc, 32'h3204);
    check("after_eret.redir", {31'b0, redirected}, 32'h0);

    // RAS overflow and underflow
    for (int i = 0; i < 5; i++) begin
      idle(); ras_push = 1; ras_push_addr = 32'hA0 + 32'(4 * i); tick("push");
    end
    check("ovf.top", ras_top, 32'hB0);
    idle(); ras_pop = 1; tick("pop1"); check("pop1.top", ras_top, 32'hAC);
    tick("pop2"); check("pop2.top", ras_top, 32'hA8);
    tick("pop3"); check("pop3.top", ras_top, 32'hA4);
    tick("pop4"); check("pop4.top", ras_top, 32'h0);
    check("pop4.valid", {31'b0, ras_valid}, 32'h0);
    tick("pop5"); check("pop5.valid", {31'b0, ras_valid}, 32'h0);

    // Push+pop replaces top; depth stays 1
    idle(); ras_push = 1; ras_push_addr = 32'h100; tick("p100");
    ras_pop = 1; ras_push_addr = 32'h200; tick("repl");
    check("repl.top", ras_top, 32'h200);
    idle(); ras_pop = 1; tick("repl_pop");
    check("repl_pop.valid", {31'b0, ras_valid}, 32'h0);

    // Suppressed pushes
    idle(); ras_push = 1; ras_push_addr = 32'h100; tick("p100b");
    stall = 1; ras_push_addr = 32'h300; tick("push_stall");
    check("push_stall.top", ras_top, 32'h100);
    stall = 0; exc_req = 1; ras_push_addr = 32'h400; tick("push_exc");
    check("push_exc.top", ras_top, 32'h100);

    // Mid-stream reset with two entries and a redirect
    idle(); ras_push = 1; ras_push_addr = 32'h500; tick("p500");
    idle(); reset = 1; redirect = 1; redirect_pc = 32'h9000; tick("midrst");
    check("midrst.pc", pc, 32'h3000);
    check("midrst.valid", {31'b0, ras_valid}, 32'h0);
    check("midrst.redir", {31'b0, redirected}, 32'h0);
    idle(); reset = 1; tick("rst_hold");
    check("rst_hold.pc", pc, 32'h3000);
    idle(); tick("rst_rel");
    check("rst_rel.pc", pc, 32'h3004);

    // Random mix
    for (int i = 0; i < 60; i++) begin
      idle();
      reset         = ($urandom_range(0, 19) == 0);
      stall         = ($urandom_range(0, 4) == 0);
      exc_req       = ($urandom_range(0, 9) == 0);
      eret          = ($urandom_range(0, 7) == 0);
      redirect      = ($urandom_range(0, 3) == 0);
      ras_push      = ($urandom_range(0, 2) == 0);
      ras_pop       = ($urandom_range(0, 2) == 0);
      eret_pc       = $urandom;
      redirect_pc   = $urandom;
      ras_push_addr = $urandom;
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the pipelined CPU fetch stage, replacing the fixed 32-bit PC register. It holds the fetch PC and selects the next PC each cycle from reset vector, exception entry, exception return, branch/jump redirect, stall hold or sequential increment. It also contains a small circular return-address stack (RAS) that decode uses to predict `jr $ra` targets.

## Interface
Parameters:
- WIDTH, 32, PC and address width in bits.
- RESET_VECTOR, 32'h0000_3000, PC value after reset.
- EXC_VECTOR, 32'h0000_4180, PC loaded on exception/interrupt entry.
- STEP, 4, sequential increment in bytes.
- RAS_DEPTH, 4, RAS entries; power of two, ≥2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- stall  in  1  hold PC and RAS; set by the hazard unit.
- exc_req  in  1  exception or interrupt entry; overrides stall.
- eret  in  1  exception return; honoured only when not stalled.
- eret_pc  in  WIDTH  EPC value from CP0.
- redirect  in  1  taken branch or jump resolved in decode.
- redirect_pc  in  WIDTH  branch or jump target.
- ras_push  in  1  push on jal/jalr.
- ras_push_addr  in  WIDTH  return address to push.
- ras_pop  in  1  pop on `jr $ra`.
- pc  out  WIDTH  current fetch PC, registered.
- pc_plus  out  WIDTH  pc + STEP, combinational, wraps modulo 2^WIDTH.
- ras_top  out  WIDTH  top RAS entry; 0 when empty.
- ras_valid  out  1  RAS non-empty.
- redirected  out  1  registered; 1 for the one cycle after a non-sequential PC load.

## Operation
- Next-PC priority, evaluated each edge:
  1. reset → RESET_VECTOR
  2. exc_req → EXC_VECTOR, regardless of stall
  3. stall → hold
  4. eret → eret_pc
  5. redirect → redirect_pc
  6. otherwise → pc + STEP
- eret and redirect together: eret wins.
- `redirected` goes to 1 on an edge where case 2, 4 or 5 loads the PC. It goes to 0 on reset, on a hold, and on a sequential step.
- No alignment check on loaded values. The PC takes the value as given.
- RAS state: RAS_DEPTH × WIDTH entry array, top pointer `sp` (log2 RAS_DEPTH bits, wraps), and `count` from 0 to RAS_DEPTH.
- RAS ops act only on edges with stall=0, exc_req=0 and reset=0. exc_req, stall and reset suppress the RAS op for that edge.
- Push only:
  - sp ← sp+1 (wrap); entry[sp+1] ← ras_push_addr.
  - count ← min(count+1, RAS_DEPTH).
  - When full, the oldest entry is overwritten and count stays at RAS_DEPTH.
- Pop only:
  - If count>0: sp ← sp−1 (wrap), count ← count−1.
  - If count=0: no change (underflow ignored).
- Push and pop together:
  - Replaces the top: entry[sp] ← ras_push_addr; sp and count unchanged.
  - If count=0, this behaves as a plain push.
- ras_top = entry[sp] when count>0, else 0. ras_valid = (count≠0). Both are combinational from registered state.
- Reset sets pc=RESET_VECTOR, count=0, sp=0 and redirected=0. Entry contents are don't-care and are never visible because count=0.
- PC arithmetic is unsigned and truncated to WIDTH.

## Timing
- pc and redirected change only on the rising edge of clk.
- Inputs sampled at edge N take effect on pc at edge N, visible in cycle N+1. Latency is 1.
- pc_plus, ras_top and ras_valid follow pc or RAS state in the same cycle with no extra latency.
- A RAS op at edge N is visible on ras_top in cycle N+1.
- Reset asserted mid-operation:
  - Takes effect at the next edge and overrides every other input.
  - While reset stays high, pc holds RESET_VECTOR.
  - The first sequential step happens on the first edge with reset=0.
- Initial value before the first reset is RESET_VECTOR, with an empty RAS.

## Test plan
- Reset then 3 free-running cycles → pc 0x3000, 0x3004, 0x3008, 0x300C; redirected=0 throughout; ras_valid=0.
- At pc=0x3010, assert stall for 2 cycles with exc_req=1 on the second → pc holds 0x3010 for one edge, then loads 0x4180; redirected=1 for the next cycle only.
- Same edge: redirect=1 with redirect_pc=0x3100 and eret=1 with eret_pc=0x3200 → pc=0x3200. Next edge, with eret=0, redirect=0 and stall=0 → pc=0x3204 and redirected=0.
- RAS_DEPTH=4: push 0xA0, 0xA4, 0xA8, 0xAC, 0xB0 → ras_top=0xB0, count stays at 4. Five pops → tops 0xAC, 0xA8, 0xA4, then empty; ras_valid=0 and ras_top=0 after the 4th pop; the 5th pop is ignored.
- Checks on a RAS holding 0x100:
  - Push 0x200 and pop on the same edge → ras_top=0x200, with depth unchanged at 1.
  - Push under stall=1 → RAS unchanged.
  - Push together with exc_req=1 → RAS unchanged.
- Reset asserted mid-stream with a 2-entry RAS and redirect=1 → pc=0x3000, ras_valid=0 and redirected=0 on the next cycle.
